// File: rtl/preg_freelist_if.sv
`default_nettype none
// ============================================================================
//  Module      : preg_freelist_if
//  Description : Bundle between rename/commit (master) and the physical
//                register free list (slave).
//                  alloc_req     m->s  rename consumes alloc_tag this cycle
//                  alloc_valid   s->m  a free tag is available
//                  alloc_tag     s->m  tag at the speculative head
//                  commit_pop    m->s  oldest speculative allocation committed
//                  free_valid    m->s  commit returns a tag
//                  free_tag      m->s  returned tag (committed rd_old_tag)
//                  flush         m->s  mispredict/exception recovery
//                  free_count    s->m  tags currently allocatable
//                  overflow_err  s->m  sticky: free arrived while full
//                  underflow_err s->m  sticky: commit_pop with nothing pending
//  Revision    : 1.0 - initial release
// ============================================================================
interface preg_freelist_if #(
    parameter int PREG_W_P = 6,
    parameter int PTR_W    = 6
);
    logic                alloc_req;
    logic                alloc_valid;
    logic [PREG_W_P-1:0] alloc_tag;
    logic                commit_pop;
    logic                free_valid;
    logic [PREG_W_P-1:0] free_tag;
    logic                flush;
    logic [PTR_W-1:0]    free_count;
    logic                overflow_err;
    logic                underflow_err;

    modport master (
        output alloc_req, commit_pop, free_valid, free_tag, flush,
        input  alloc_valid, alloc_tag, free_count, overflow_err, underflow_err
    );

    modport slave (
        input  alloc_req, commit_pop, free_valid, free_tag, flush,
        output alloc_valid, alloc_tag, free_count, overflow_err, underflow_err
    );
endinterface
`default_nettype wire

// File: rtl/preg_freelist.sv
`default_nettype none
// ============================================================================
//  Module      : preg_freelist
//  Description : Physical-register free list with a speculative head (rename
//                allocation), an architectural head (commit) and a tail
//                (tags returned at commit). Flush rewinds the speculative
//                head to the architectural head in one cycle.
//  Ports       : clk  - clock
//                rst  - synchronous active-high reset
//                fl   - preg_freelist_if.slave (alloc / commit / free / flush
//                       handshake, free_count and sticky error flags)
//  Revision    : 1.0 - initial release
// ============================================================================
module preg_freelist #(
    parameter int N_PHYS_REGS_P = 64,
    parameter int N_ARCH_REGS_P = 32,
    parameter int PREG_W_P      = 6,
    parameter int DEPTH         = N_PHYS_REGS_P - N_ARCH_REGS_P,
    parameter int PTR_W         = $clog2(DEPTH) + 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    preg_freelist_if.slave   fl
);

    localparam int               c_IDX_W     = PTR_W - 1;
    localparam logic [PTR_W-1:0] c_DEPTH_PTR = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_PTR_ONE   = PTR_W'(1);

    logic [PREG_W_P-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]    r_head_spec;
    logic [PTR_W-1:0]    r_head_arch;
    logic [PTR_W-1:0]    r_tail;
    logic                r_overflow_err;
    logic                r_underflow_err;

    logic                w_full;
    logic                w_alloc_valid;
    logic                w_alloc_fire;
    logic                w_commit_fire;
    logic                w_free_fire;
    logic [PTR_W-1:0]    w_head_arch_nxt;
    logic [PTR_W-1:0]    w_head_spec_nxt;
    logic [PTR_W-1:0]    w_tail_nxt;

    // Fullness is measured from the architectural head so that slots still
    // owned by in-flight (uncommitted) allocations are never overwritten.
    assign w_full        = ((r_tail - r_head_arch) == c_DEPTH_PTR);
    assign w_alloc_valid = (r_head_spec != r_tail);

    assign w_alloc_fire  = fl.alloc_req && w_alloc_valid && !fl.flush;
    assign w_commit_fire = fl.commit_pop && (r_head_arch != r_head_spec);
    assign w_free_fire   = fl.free_valid && !w_full;

    always_comb begin
        w_head_arch_nxt = r_head_arch;
        w_head_spec_nxt = r_head_spec;
        w_tail_nxt      = r_tail;
        if (w_commit_fire) begin
            w_head_arch_nxt = r_head_arch + c_PTR_ONE;
        end
        if (w_free_fire) begin
            w_tail_nxt = r_tail + c_PTR_ONE;
        end
        // Flush rewinds to the post-commit architectural head, so a commit
        // landing in the same cycle is not lost.
        if (fl.flush) begin
            w_head_spec_nxt = w_head_arch_nxt;
        end else if (w_alloc_fire) begin
            w_head_spec_nxt = r_head_spec + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_spec     <= '0;
            r_head_arch     <= '0;
            r_tail          <= c_DEPTH_PTR;
            r_overflow_err  <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            r_head_spec <= w_head_spec_nxt;
            r_head_arch <= w_head_arch_nxt;
            r_tail      <= w_tail_nxt;
            if (fl.free_valid && w_full) begin
                r_overflow_err <= 1'b1;
            end
            if (fl.commit_pop && !w_commit_fire) begin
                r_underflow_err <= 1'b1;
            end
        end
    end

    // Storage starts out holding every non-architectural tag in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= PREG_W_P'(N_ARCH_REGS_P + i);
            end
        end else if (w_free_fire) begin
            r_mem[r_tail[c_IDX_W-1:0]] <= fl.free_tag;
        end
    end

    assign fl.alloc_valid   = w_alloc_valid;
    assign fl.alloc_tag     = r_mem[r_head_spec[c_IDX_W-1:0]];
    assign fl.free_count    = r_tail - r_head_spec;
    assign fl.overflow_err  = r_overflow_err;
    assign fl.underflow_err = r_underflow_err;

endmodule
`default_nettype wire
